// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter and FIFO status logic.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Defaults shared with the FIFO status logic so both sides agree on sizing.
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_BURST_MAX = 4;

    // Width of a producer index.
    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Width of a beat counter able to hold 0..burst_max.
    function automatic int cnt_w(input int burst_max);
        return $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority picker: first set request after last_owner, wrapping modulo N_REQ.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when to register the winner.
//
// Ports:
//   req        N_REQ-bit request vector
//   last_owner index of the previous winner; search starts at last_owner+1
//   winner     index of the selected requester (0 when any==0)
//   any        at least one request bit is set
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_owner,
    output logic [ID_W-1:0]  winner,
    output logic             any
);

    logic [ID_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit after
    // last_owner overwrites earlier ones and ends up as the winner.
    // The modulo keeps the wrap correct for non-power-of-two N_REQ.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx = ID_W'((int'(last_owner) + off) % N_REQ);
            if (req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bursts up to BURST_MAX.
// Latency: grant one cycle after valid is seen in IDLE; data path to FIFO is combinational.
// Backpressure: fifo_full combinationally drops req_ready/fifo_wr_en; grant is held while stalled.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   req_valid/req_data        per-producer beat valid and packed data (producer i at [i*DATA_SIZE +: DATA_SIZE])
//   req_ready                 per-producer accept, one-hot or zero
//   fifo_full                 FIFO cannot take a write this cycle
//   fifo_wr_en/fifo_wr_data   FIFO write port
//   grant_active/grant_id     a producer owns the port / current or last owner index
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter  int NUM_REQ   = DEF_NUM_REQ,
    parameter  int DATA_SIZE = DEF_DATA_SIZE,
    parameter  int BURST_MAX = DEF_BURST_MAX,
    localparam int ID_W      = id_w(NUM_REQ),
    localparam int CNT_W     = cnt_w(BURST_MAX)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
    output logic [DATA_SIZE-1:0]           fifo_wr_data,
    output logic                           grant_active,
    output logic [ID_W-1:0]                grant_id
);

    localparam logic [ID_W-1:0]  LAST_ID_RST = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BURST_MAX - 1);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  last_owner_q, last_owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0]  pick_id;
    logic             pick_any;
    logic             owner_valid;
    logic             xfer;
    logic             burst_done;

    rr_pick #(
        .N_REQ (NUM_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_owner (last_owner_q),
        .winner     (pick_id),
        .any        (pick_any)
    );

    assign owner_valid = req_valid[owner_q];
    assign xfer        = (state_q == GRANT) & owner_valid & ~fifo_full;
    // A stalled final beat is not a transfer, so the burst only ends once it is accepted.
    assign burst_done  = xfer & (beat_cnt_q == LAST_BEAT);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_any) state_d = GRANT;
            GRANT:   if (!owner_valid || burst_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready    = '0;
        grant_active = (state_q == GRANT);
        if (state_q == GRANT) begin
            req_ready[owner_q] = ~fifo_full;
        end
    end

    assign fifo_wr_en   = xfer;
    assign fifo_wr_data = req_data[owner_q*DATA_SIZE +: DATA_SIZE];
    assign grant_id     = owner_q;

    // Owner / beat counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q      <= '0;
            last_owner_q <= LAST_ID_RST;
            beat_cnt_q   <= '0;
        end else begin
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        if (state_q == IDLE) begin
            if (pick_any) begin
                owner_d      = pick_id;
                last_owner_d = pick_id;
                beat_cnt_d   = '0;
            end
        end else if (xfer) begin
            // Wrap to zero on the last beat so the counter never exceeds BURST_MAX-1.
            beat_cnt_d = burst_done ? '0 : beat_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset_n;

    // 4-producer instance
    logic [3:0]  v4;
    logic [31:0] d4;
    logic        full4;
    logic [3:0]  rdy4;
    logic        wen4;
    logic [7:0]  wdat4;
    logic        gact4;
    logic [1:0]  gid4;

    // 3-producer instance
    logic [2:0]  v3;
    logic [23:0] d3;
    logic        full3;
    logic [2:0]  rdy3;
    logic        wen3;
    logic [7:0]  wdat3;
    logic        gact3;
    logic [1:0]  gid3;

    int n_err;
    int n_checks;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_SIZE(8), .BURST_MAX(4)) u_dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (v4),
        .req_data     (d4),
        .req_ready    (rdy4),
        .fifo_full    (full4),
        .fifo_wr_en   (wen4),
        .fifo_wr_data (wdat4),
        .grant_active (gact4),
        .grant_id     (gid4)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_SIZE(8), .BURST_MAX(4)) u_dut3 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (v3),
        .req_data     (d3),
        .req_ready    (rdy3),
        .fifo_full    (full3),
        .fifo_wr_en   (wen3),
        .fifo_wr_data (wdat3),
        .grant_active (gact3),
        .grant_id     (gid3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] valid;
        logic [7:0] d0;
        logic       full;
        logic [3:0] e_rdy;
        logic       e_wen;
        logic [7:0] e_wdat;
        logic       e_gact;
        logic [1:0] e_gid;
    } vec_t;

    vec_t       tbl [20];
    logic [7:0] pdata [4];

    function automatic vec_t mk(input logic [3:0] valid, input logic [7:0] d0, input logic full,
                                input logic [3:0] e_rdy, input logic e_wen, input logic [7:0] e_wdat,
                                input logic e_gact, input logic [1:0] e_gid);
        vec_t r;
        r.valid = valid; r.d0 = d0; r.full = full;
        r.e_rdy = e_rdy; r.e_wen = e_wen; r.e_wdat = e_wdat;
        r.e_gact = e_gact; r.e_gid = e_gid;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_d4();
        for (int i = 0; i < 4; i++) d4[i*8 +: 8] = pdata[i];
    endtask

    initial begin
        n_err    = 0;
        n_checks = 0;
        reset_n  = 1'b0;
        v4 = '0; d4 = 32'h44332211; full4 = 1'b0;
        v3 = '0; d3 = 24'hA2A1A0;   full3 = 1'b0;

        // Single producer 0, 6 beats, plus stall and stalled-final-beat cases.
        tbl[0]  = mk(4'b0001, 8'h10, 1'b0, 4'b0000, 1'b0, 8'h10, 1'b0, 2'd0);
        tbl[1]  = mk(4'b0001, 8'h10, 1'b0, 4'b0001, 1'b1, 8'h10, 1'b1, 2'd0);
        tbl[2]  = mk(4'b0001, 8'h11, 1'b0, 4'b0001, 1'b1, 8'h11, 1'b1, 2'd0);
        tbl[3]  = mk(4'b0001, 8'h12, 1'b0, 4'b0001, 1'b1, 8'h12, 1'b1, 2'd0);
        tbl[4]  = mk(4'b0001, 8'h13, 1'b0, 4'b0001, 1'b1, 8'h13, 1'b1, 2'd0);
        tbl[5]  = mk(4'b0001, 8'h14, 1'b0, 4'b0000, 1'b0, 8'h14, 1'b0, 2'd0);
        tbl[6]  = mk(4'b0001, 8'h14, 1'b0, 4'b0001, 1'b1, 8'h14, 1'b1, 2'd0);
        tbl[7]  = mk(4'b0001, 8'h15, 1'b0, 4'b0001, 1'b1, 8'h15, 1'b1, 2'd0);
        tbl[8]  = mk(4'b0000, 8'h15, 1'b0, 4'b0001, 1'b0, 8'h15, 1'b1, 2'd0);
        tbl[9]  = mk(4'b0000, 8'h15, 1'b0, 4'b0000, 1'b0, 8'h15, 1'b0, 2'd0);
        tbl[10] = mk(4'b0001, 8'h20, 1'b0, 4'b0000, 1'b0, 8'h20, 1'b0, 2'd0);
        tbl[11] = mk(4'b0001, 8'h20, 1'b0, 4'b0001, 1'b1, 8'h20, 1'b1, 2'd0);
        tbl[12] = mk(4'b0001, 8'h21, 1'b0, 4'b0001, 1'b1, 8'h21, 1'b1, 2'd0);
        tbl[13] = mk(4'b0001, 8'h22, 1'b1, 4'b0000, 1'b0, 8'h22, 1'b1, 2'd0);
        tbl[14] = mk(4'b0001, 8'h22, 1'b1, 4'b0000, 1'b0, 8'h22, 1'b1, 2'd0);
        tbl[15] = mk(4'b0001, 8'h22, 1'b1, 4'b0000, 1'b0, 8'h22, 1'b1, 2'd0);
        tbl[16] = mk(4'b0001, 8'h22, 1'b0, 4'b0001, 1'b1, 8'h22, 1'b1, 2'd0);
        tbl[17] = mk(4'b0001, 8'h23, 1'b1, 4'b0000, 1'b0, 8'h23, 1'b1, 2'd0);
        tbl[18] = mk(4'b0001, 8'h23, 1'b0, 4'b0001, 1'b1, 8'h23, 1'b1, 2'd0);
        tbl[19] = mk(4'b0000, 8'h23, 1'b0, 4'b0000, 1'b0, 8'h23, 1'b0, 2'd0);

        // Reset state
        #2;
        chk("rst_ready",  32'(rdy4),  32'h0);
        chk("rst_wr_en",  32'(wen4),  32'h0);
        chk("rst_gact",   32'(gact4), 32'h0);
        chk("rst_gid",    32'(gid4),  32'h0);
        chk("rst_wdat",   32'(wdat4), 32'h11);
        chk("rst3_wdat",  32'(wdat3), 32'hA0);
        step();
        step();
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            v4    = tbl[i].valid;
            d4    = {24'h0, tbl[i].d0};
            full4 = tbl[i].full;
            #2;
            chk($sformatf("row%0d_ready", i), 32'(rdy4),  32'(tbl[i].e_rdy));
            chk($sformatf("row%0d_wr_en", i), 32'(wen4),  32'(tbl[i].e_wen));
            chk($sformatf("row%0d_wdat", i),  32'(wdat4), 32'(tbl[i].e_wdat));
            chk($sformatf("row%0d_gact", i),  32'(gact4), 32'(tbl[i].e_gact));
            chk($sformatf("row%0d_gid", i),   32'(gid4),  32'(tbl[i].e_gid));
            step();
        end

        // All four continuously valid after a fresh reset: grants 0,1,2,3,0, four beats each.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) pdata[i] = 8'((i << 4));
        v4 = 4'hF;
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % 4;
            pack_d4();
            #1;
            chk($sformatf("rr%0d_bubble_gact", g), 32'(gact4), 32'h0);
            step();
            for (int b = 0; b < 4; b++) begin
                pack_d4();
                #2;
                chk($sformatf("rr%0d_b%0d_gid", g, b),   32'(gid4),  32'(e));
                chk($sformatf("rr%0d_b%0d_wr_en", g, b), 32'(wen4),  32'h1);
                chk($sformatf("rr%0d_b%0d_wdat", g, b),  32'(wdat4), 32'(pdata[e]));
                chk($sformatf("rr%0d_b%0d_ready", g, b), 32'(rdy4),  32'(1 << e));
                pdata[e] = pdata[e] + 8'd1;
                step();
            end
        end

        // Producer 1 drops valid after 2 beats; producer 2 is next.
        v4 = 4'b0110;
        pack_d4();
        #2;
        chk("drop_idle_gact", 32'(gact4), 32'h0);
        step();
        for (int b = 0; b < 2; b++) begin
            #2;
            chk($sformatf("drop_b%0d_gid", b),   32'(gid4), 32'h1);
            chk($sformatf("drop_b%0d_wr_en", b), 32'(wen4), 32'h1);
            step();
        end
        v4 = 4'b0100;
        #2;
        chk("drop_rel_gact",  32'(gact4), 32'h1);
        chk("drop_rel_wr_en", 32'(wen4),  32'h0);
        step();
        #2;
        chk("drop_bubble_gact", 32'(gact4), 32'h0);
        step();
        #2;
        chk("p2_b0_gid",   32'(gid4),  32'h2);
        chk("p2_b0_wr_en", 32'(wen4),  32'h1);
        chk("p2_b0_wdat",  32'(wdat4), 32'(pdata[2]));
        step();
        #2;
        chk("p2_b1_wr_en", 32'(wen4), 32'h1);
        step();

        // Reset pulse during beat 2 of producer 2.
        v4 = 4'b0101;
        #1;
        chk("p2_b2_wr_en", 32'(wen4), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("arst_gact",  32'(gact4), 32'h0);
        chk("arst_ready", 32'(rdy4),  32'h0);
        chk("arst_wr_en", 32'(wen4),  32'h0);
        chk("arst_gid",   32'(gid4),  32'h0);
        chk("arst_wdat",  32'(wdat4), 32'(pdata[0]));
        step();
        reset_n = 1'b1;
        #2;
        chk("post_rst_idle", 32'(gact4), 32'h0);
        step();
        #2;
        chk("post_rst_gact", 32'(gact4), 32'h1);
        chk("post_rst_gid",  32'(gid4),  32'h0);
        step();
        v4 = '0;

        // NUM_REQ=3 with producers 1 and 2 valid: alternate 1,2,1,2 with wrap past idle 0.
        v3 = 3'b110;
        for (int g = 0; g < 4; g++) begin
            int e;
            e = (g % 2 == 0) ? 1 : 2;
            #2;
            chk($sformatf("n3_g%0d_bubble", g), 32'(gact3), 32'h0);
            step();
            for (int b = 0; b < 4; b++) begin
                #2;
                chk($sformatf("n3_g%0d_b%0d_gid", g, b),  32'(gid3),  32'(e));
                chk($sformatf("n3_g%0d_b%0d_wen", g, b),  32'(wen3),  32'h1);
                chk($sformatf("n3_g%0d_b%0d_wdat", g, b), 32'(wdat3), 32'(8'hA0 + e));
                chk($sformatf("n3_g%0d_b%0d_rdy", g, b),  32'(rdy3),  32'(1 << e));
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
